instr_fetch_stage: RTL and testbench
====================================

// Module: instr_fetch_stage
// PURPOSE
//  Fetch stage directly upstream of the instruction decode/control stage. Holds the PC,
//  issues single-outstanding requests to instruction memory, and presents instr/pc with
//  a valid/ready handshake. Decode takes if_instr[31:26] as the opcode. Fetch stalls
//  under decode back-pressure; branch/jump resolution flushes it via redirect.
// PARAMETERS
//  ADDR_W    32  PC / memory address width
//  DATA_W    32  instruction width; opcode = if_instr[DATA_W-1 -: 6]
//  RESET_PC  0   PC value loaded on reset
//  PC_STEP   4   PC increment per sequential fetch
// PORTS
//  clk             in   1       clock, rising edge
//  rst             in   1       asynchronous, active-high reset
//  imem_req        out  1       request strobe, one cycle per request
//  imem_addr       out  ADDR_W  request address, valid while imem_req=1
//  imem_rdata      in   DATA_W  returned instruction, valid while imem_valid=1
//  imem_valid      in   1       response strobe, >=1 cycle after imem_req, in order
//  redirect_valid  in   1       branch taken / jump: flush and refetch from redirect_pc
//  redirect_pc     in   ADDR_W  redirect target
//  if_valid        out  1       if_instr/if_pc hold a valid instruction
//  if_instr        out  DATA_W  fetched instruction
//  if_pc           out  ADDR_W  address of if_instr
//  id_ready        in   1       decode accepts; transfer = if_valid & id_ready
// BEHAVIOUR
//  Reset (async): state=IDLE, pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, imem_req=0.
//   Reset mid-request drops the request; the memory returns no response after reset.
//  States: IDLE, FETCH, WAIT, DRAIN.
//  - IDLE: entered on reset only; next cycle goes to FETCH.
//  - FETCH: out_free = !if_valid | id_ready.
//    - If redirect_valid: imem_req=0, pc<=redirect_pc, stay in FETCH.
//    - Else if out_free: imem_req=1, imem_addr=pc, go to WAIT.
//    - Else: imem_req=0, stay in FETCH.
//  - WAIT: imem_req=0.
//    - If redirect_valid & imem_valid: discard response, pc<=redirect_pc, go to FETCH.
//    - If redirect_valid only: pc<=redirect_pc, go to DRAIN.
//    - If imem_valid only: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1,
//      pc<=pc+PC_STEP (mod 2^ADDR_W), go to FETCH.
//  - DRAIN: imem_req=0. On imem_valid, discard data and go to FETCH.
//    A further redirect_valid updates pc and stays in DRAIN.
//  Output register: if_valid clears on transfer unless reloaded in the same cycle.
//   redirect_valid in any state clears if_valid next cycle (flush of the wrong-path
//   instruction). Redirect beats load and transfer in the same cycle.
//  While if_valid & !id_ready, if_instr and if_pc are held stable.
//  At most one request outstanding. Latency from imem_req to if_valid = memory latency + 1.
//   Back-to-back request spacing is >= 2 cycles (FETCH, WAIT).
//  PC wraps modulo 2^ADDR_W; RESET_PC and redirect_pc are not alignment-checked.
//  imem_addr = pc whenever imem_req=0 (no X on the bus).
// TESTING
//  1 Release reset with 1-cycle memory, id_ready=1 -> imem_addr sequence 0,4,8;
//    if_pc 0,4,8 with if_valid high; first if_valid 3 cycles after reset release.
//  2 Hold id_ready=0 with if_instr=0x8C220004 -> instr/pc held stable, no new imem_req,
//    until id_ready=1; the next request is issued in that same cycle.
//  3 redirect_valid with redirect_pc=0x100 while WAIT, response 2 cycles later ->
//    state DRAIN, response dropped; next imem_addr=0x100; if_valid low until it returns.
//  4 redirect_valid and imem_valid in the same WAIT cycle ->
//    no if_valid for that data; imem_req to redirect_pc next cycle.
//  5 redirect while if_valid=1 and id_ready=0 -> if_valid=0 next cycle, no transfer.
//  6 Assert rst during WAIT, pc=0x40 -> all outputs at reset values immediately;
//    fetch restarts at RESET_PC. Also pc=0xFFFFFFFC with PC_STEP=4 -> next pc=0x0.

Source files
------------

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: holds the PC, keeps at most one instruction-memory
// request in flight and hands instructions to decode through a valid/ready register.
module instr_fetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
  parameter int                PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_valid,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              id_ready
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(PC_STEP);

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] pc_r, pc_s;
  logic              req_s;
  logic              load_s;
  logic              out_free_s;
  logic              transfer_s;

  assign transfer_s = if_valid & id_ready;
  assign out_free_s = ~if_valid | id_ready;
  assign imem_req   = req_s;
  assign imem_addr  = pc_r;

  // State and PC registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      pc_r    <= RESET_PC;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
    end
  end

  // Next-state, next-PC and request strobe
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    req_s   = 1'b0;
    load_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        state_s = ST_FETCH;
      end
      ST_FETCH: begin
        if (redirect_valid) begin
          pc_s = redirect_pc;
        end else if (out_free_s) begin
          req_s   = 1'b1;
          state_s = ST_WAIT;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_WAIT: begin
        // A redirect always wins over a returning response: that data is wrong-path.
        if (redirect_valid && imem_valid) begin
          pc_s    = redirect_pc;
          state_s = ST_FETCH;
        end else if (redirect_valid) begin
          pc_s    = redirect_pc;
          state_s = ST_DRAIN;
        end else if (imem_valid) begin
          load_s  = 1'b1;
          pc_s    = pc_r + PC_INC;
          state_s = ST_FETCH;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (redirect_valid) begin
          pc_s = redirect_pc;
        end else begin
          pc_s = pc_r;
        end
        if (imem_valid) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output register towards decode; a redirect flushes whatever it holds
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid <= 1'b0;
      if_instr <= {DATA_W{1'b0}};
      if_pc    <= {ADDR_W{1'b0}};
    end else if (redirect_valid) begin
      if_valid <= 1'b0;
    end else if (load_s) begin
      if_valid <= 1'b1;
      if_instr <= imem_rdata;
      if_pc    <= pc_r;
    end else if (transfer_s) begin
      if_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Randomized bench for instr_fetch_stage: memory responder with variable latency,
// transaction-level reference model and a scoreboard checked on every low clock phase.
module tb_instr_fetch_stage;

  localparam logic [31:0] STEP = 32'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_valid = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready = 1'b1;

  instr_fetch_stage #(
    .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0000_0000), .PC_STEP(4)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Environment state shared between driver (writes flags) and monitor (owns memory).
  int   mem_cnt = 0;
  logic [31:0] mem_addr = 32'd0;
  logic fixed_lat = 1'b1;
  logic boot = 1'b1;
  logic wait_ok = 1'b0;
  logic finish_req = 1'b0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h8C22_0004;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, scoreboard and memory responder
  initial begin : monitor
    logic [31:0] qi[$];
    logic [31:0] qp[$];
    logic [31:0] pc_m;
    logic [31:0] req_addr_m;
    logic        outst, poisoned, idle_m, exp_v, req_exp;
    int          since_rst, nreq, starve, ntx;
    logic        first_seen;
    pc_m = 32'd0; req_addr_m = 32'd0; outst = 1'b0; poisoned = 1'b0; idle_m = 1'b1;
    since_rst = 0; nreq = 0; starve = 0; ntx = 0; first_seen = 1'b0;
    forever begin
      @(negedge clk or posedge rst);
      if (clk) begin
        #1;
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'd0);
        chk("rst_during_wait", {31'd0, wait_ok}, 32'd1);
      end else if (finish_req) begin
        chk("transfers_seen", {31'd0, ntx > 200}, 32'd1);
      end else if (rst) begin
        qi.delete(); qp.delete();
        pc_m = 32'd0; outst = 1'b0; poisoned = 1'b0; idle_m = 1'b1;
        since_rst = 0; starve = 0; mem_cnt = 0;
        chk("in_rst_req", {31'd0, imem_req}, 32'd0);
        chk("in_rst_valid", {31'd0, if_valid}, 32'd0);
      end else begin
        since_rst++;
        exp_v = (qi.size() != 0);
        chk("if_valid", {31'd0, if_valid}, {31'd0, exp_v});
        if (if_valid && exp_v) begin
          chk("if_instr", if_instr, qi[0]);
          chk("if_pc", if_pc, qp[0]);
        end
        req_exp = !outst && !idle_m && !redirect_valid && (!exp_v || id_ready);
        chk("imem_req", {31'd0, imem_req}, {31'd0, req_exp});
        chk("imem_addr", imem_addr, pc_m);
        if (boot && imem_req && nreq < 3) begin
          chk("boot_addr_seq", imem_addr, 32'(nreq) * STEP);
          nreq++;
        end
        // Released in low phase 1; data loads on the 3rd rising edge after release.
        if (boot && if_valid && !first_seen) begin
          chk("first_valid_latency", 32'(since_rst), 32'd4);
          first_seen = 1'b1;
        end
        if (if_valid && id_ready && exp_v) begin
          void'(qi.pop_front()); void'(qp.pop_front());
          starve = 0; ntx++;
        end else begin
          starve++;
          if (starve == 300) chk("progress", 32'd0, 32'd1);
        end
        idle_m = 1'b0;
        if (imem_valid && outst) begin
          outst = 1'b0;
          if (!poisoned && !redirect_valid) begin
            qi.push_back(memfn(req_addr_m));
            qp.push_back(req_addr_m);
            pc_m = req_addr_m + STEP;
          end
          poisoned = 1'b0;
        end
        if (redirect_valid) begin
          qi.delete(); qp.delete();
          pc_m = redirect_pc;
          if (outst) poisoned = 1'b1;
        end
        if (imem_req) begin
          outst = 1'b1;
          req_addr_m = pc_m;
          mem_cnt = fixed_lat ? 1 : int'($urandom_range(1, 3));
          mem_addr = imem_addr;
        end else if (mem_cnt > 0) begin
          mem_cnt--;
        end
      end
    end
  end

  // Stimulus: drives inputs just after each rising edge
  initial begin : driver
    int quiet;
    int waited;
    logic [1:0] sel;
    quiet = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (i == 20) fixed_lat = 1'b0;
      if (i == 1500) begin
        boot = 1'b0;
        waited = 0;
        while (mem_cnt < 2 && waited < 60) begin
          imem_valid = (mem_cnt == 1);
          imem_rdata = memfn(mem_addr);
          redirect_valid = 1'b0;
          id_ready = 1'b1;
          @(posedge clk); #1;
          waited++;
        end
        wait_ok = (mem_cnt >= 2);
        rst = 1'b1;
        imem_valid = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        quiet = 5;
      end
      imem_valid = (mem_cnt == 1);
      imem_rdata = (mem_cnt == 1) ? memfn(mem_addr) : $urandom;
      if (i < 20) begin
        id_ready = 1'b1;
        redirect_valid = 1'b0;
      end else begin
        id_ready = ($urandom_range(0, 9) < 7);
        redirect_valid = (quiet == 0) && ($urandom_range(0, 99) < 6);
        sel = 2'($urandom_range(0, 3));
        case (sel)
          2'd0:    redirect_pc = 32'h0000_0100;
          2'd1:    redirect_pc = 32'hFFFF_FFFC;
          2'd2:    redirect_pc = 32'hFFFF_FFF8;
          default: redirect_pc = $urandom & 32'hFFFF_FFFC;
        endcase
      end
      if (quiet > 0) quiet--;
    end
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    finish_req = 1'b1;
    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
